// File: rtl/matrix_seq_coprocessor.sv
// matrix_seq_coprocessor: sequential 5x5 signed matrix engine, one result element per step,
// multiply built from one MAC per cycle, with a one-cycle done pulse.
module matrix_seq_coprocessor #(
    parameter int ELEM_W  = 8,
    parameter int MAX_DIM = 5,
    parameter int ACC_W   = 20
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                start,
    input  logic [2:0]                          op_code,
    input  logic [1:0]                          matrix_size,
    input  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0]   matrix_a,
    input  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0]   matrix_b,
    output logic [MAX_DIM*MAX_DIM*ELEM_W-1:0]   result_final,
    output logic                                process_done,
    output logic                                busy,
    output logic                                op_error
);
    localparam int MW = MAX_DIM * MAX_DIM * ELEM_W;
    localparam int IW = $clog2(MAX_DIM * MAX_DIM);
    localparam int DW = $clog2(MAX_DIM + 1);
    localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((1 << (ELEM_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SMIN = -SMAX - ACC_W'(1);

    typedef enum logic [1:0] {IDLE, RUN, MAC, DONE} state_t;

    state_t state_q, state_d;
    logic [2:0]              op_q, op_d;
    logic [DW-1:0]           n_q, n_d, r_q, r_d, c_q, c_d, k_q, k_d;
    logic [MW-1:0]           a_q, a_d, b_q, b_d, res_q, res_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    done_q, done_d, busy_q, busy_d, err_q, err_d;

    function automatic logic signed [ACC_W-1:0] sx(input logic [ELEM_W-1:0] v);
        return {{(ACC_W-ELEM_W){v[ELEM_W-1]}}, v};
    endfunction

    function automatic logic [ELEM_W-1:0] sat(input logic signed [ACC_W-1:0] v);
        return v > SMAX ? SMAX[ELEM_W-1:0] : v < SMIN ? SMIN[ELEM_W-1:0] : v[ELEM_W-1:0];
    endfunction

    logic [IW-1:0]           idx, tidx, ia, ib;
    logic signed [ACC_W-1:0] ea, eb, eb0, ema, emb, mac_sum;
    logic [ELEM_W-1:0]       op_elem, elem;
    logic accept, is_mul, invalid, in_reg, last, k_last, wr;

    assign accept  = state_q == IDLE && start;
    assign is_mul  = op_q == 3'b010;
    assign invalid = op_q[2] & op_q[1];
    assign in_reg  = r_q < n_q && c_q < n_q;
    assign last    = r_q == DW'(MAX_DIM - 1) && c_q == DW'(MAX_DIM - 1);
    assign k_last  = k_q == n_q - DW'(1);
    assign idx     = IW'(r_q) * IW'(MAX_DIM) + IW'(c_q);
    assign tidx    = IW'(c_q) * IW'(MAX_DIM) + IW'(r_q);
    assign ia      = IW'(r_q) * IW'(MAX_DIM) + IW'(k_q);
    assign ib      = IW'(k_q) * IW'(MAX_DIM) + IW'(c_q);
    assign ea      = sx(a_q[idx*ELEM_W +: ELEM_W]);
    assign eb      = sx(b_q[idx*ELEM_W +: ELEM_W]);
    assign eb0     = sx(b_q[ELEM_W-1:0]);
    assign ema     = sx(a_q[ia*ELEM_W +: ELEM_W]);
    assign emb     = sx(b_q[ib*ELEM_W +: ELEM_W]);
    assign mac_sum = acc_q + ema * emb;

    // Per-element result for every op that completes in a single RUN step.
    assign op_elem = op_q == 3'b000 ? sat(ea + eb) :
                     op_q == 3'b001 ? sat(ea - eb) :
                     op_q == 3'b011 ? sat(ea * eb0) :
                     op_q == 3'b100 ? a_q[tidx*ELEM_W +: ELEM_W] :
                     op_q == 3'b101 ? sat(-ea) : '0;
    assign elem    = !in_reg ? '0 : state_q == MAC ? sat(mac_sum) : op_elem;
    assign wr      = (state_q == RUN && !(is_mul && in_reg)) || (state_q == MAC && k_last);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            n_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            acc_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            n_q     <= n_d;
            r_q     <= r_d;
            c_q     <= c_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? RUN : IDLE;
            RUN:     state_d = is_mul && in_reg ? MAC : last ? DONE : RUN;
            MAC:     state_d = !k_last ? MAC : last ? DONE : RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        op_d  = op_q;
        n_d   = n_q;
        a_d   = a_q;
        b_d   = b_q;
        r_d   = r_q;
        c_d   = c_q;
        k_d   = k_q;
        acc_d = acc_q;
        res_d = res_q;
        if (accept) begin
            op_d  = op_code;
            n_d   = DW'(matrix_size) + DW'(2);
            a_d   = matrix_a;
            b_d   = matrix_b;
            r_d   = '0;
            c_d   = '0;
            res_d = '0;
        end
        if (state_q == RUN && is_mul && in_reg) begin
            acc_d = '0;
            k_d   = '0;
        end
        if (state_q == MAC) begin
            acc_d = mac_sum;
            k_d   = k_q + DW'(1);
        end
        if (wr) begin
            res_d[idx*ELEM_W +: ELEM_W] = elem;
            c_d = c_q == DW'(MAX_DIM - 1) ? '0 : c_q + DW'(1);
            r_d = c_q == DW'(MAX_DIM - 1) ? r_q + DW'(1) : r_q;
        end
    end

    always_comb begin
        done_d = state_q == DONE;
        busy_d = accept ? 1'b1 : state_q == DONE ? 1'b0 : busy_q;
        err_d  = accept ? 1'b0 : state_q == DONE ? invalid : err_q;
    end

    assign result_final = res_q;
    assign process_done = done_q;
    assign busy         = busy_q;
    assign op_error     = err_q;
endmodule

// File: tb/tb_matrix_seq_coprocessor.sv
// tb_matrix_seq_coprocessor: directed and random operations checked against an
// element-wise arithmetic model of the coprocessor.
module tb_matrix_seq_coprocessor;
    logic         clk = 1'b0;
    logic         reset_n, start;
    logic [2:0]   op_code;
    logic [1:0]   matrix_size;
    logic [199:0] matrix_a, matrix_b, result_final;
    logic         process_done, busy, op_error;
    int           n_vec = 0, n_err = 0;

    matrix_seq_coprocessor dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op_code(op_code),
        .matrix_size(matrix_size), .matrix_a(matrix_a), .matrix_b(matrix_b),
        .result_final(result_final), .process_done(process_done), .busy(busy),
        .op_error(op_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int el(input logic [199:0] m, input int i);
        logic signed [7:0] v;
        v = m[i*8 +: 8];
        return int'(v);
    endfunction

    function automatic int sat8(input int v);
        return v > 127 ? 127 : v < -128 ? -128 : v;
    endfunction

    function automatic logic [199:0] model(input logic [2:0] op, input int n,
                                           input logic [199:0] a, input logic [199:0] b);
        logic [199:0] res;
        int v;
        res = '0;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                case (op)
                    3'd0: v = sat8(el(a, r*5+c) + el(b, r*5+c));
                    3'd1: v = sat8(el(a, r*5+c) - el(b, r*5+c));
                    3'd2: begin
                        v = 0;
                        for (int k = 0; k < n; k++) v += el(a, r*5+k) * el(b, k*5+c);
                        v = sat8(v);
                    end
                    3'd3: v = sat8(el(a, r*5+c) * el(b, 0));
                    3'd4: v = el(a, c*5+r);
                    3'd5: v = sat8(-el(a, r*5+c));
                    default: v = 0;
                endcase
                res[(r*5+c)*8 +: 8] = 8'(v);
            end
        return res;
    endfunction

    // Called at a negedge; leaves the bench at the negedge where done was seen.
    task automatic run_op(input logic [2:0] op, input logic [1:0] sz,
                          input logic [199:0] a, input logic [199:0] b, input bit hold);
        int n, cnt, exp_lat;
        bit busy_ok;
        logic [199:0] exp;
        n = int'(sz) + 2;
        exp = model(op, n, a, b);
        exp_lat = op == 3'd2 ? n*n*(n+1) + (25 - n*n) + 1 : 26;
        op_code = op; matrix_size = sz; matrix_a = a; matrix_b = b; start = 1'b1;
        @(negedge clk);
        start = hold;
        matrix_a = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        op_code = 3'($urandom);
        busy_ok = 1'b1;
        cnt = 0;
        while (!process_done && cnt < 400) begin
            busy_ok &= busy;
            @(negedge clk);
            cnt++;
        end
        chk($sformatf("lat op%0d n%0d", op, n), 256'(cnt), 256'(exp_lat));
        chk("busy_run", 256'(busy_ok), 256'(1));
        chk("busy_done", 256'(busy), 256'(0));
        chk("op_error", 256'(op_error), 256'(op[2] & op[1]));
        chk($sformatf("result op%0d n%0d", op, n), 256'(result_final), 256'(exp));
    endtask

    task automatic after_done(input logic [199:0] exp);
        @(negedge clk);
        chk("pulse_len", 256'(process_done), 256'(0));
        chk("result_hold", 256'(result_final), 256'(exp));
    endtask

    logic [199:0] a, b, r0;
    bit seen;

    initial begin
        reset_n = 1'b0; start = 1'b0; op_code = '0; matrix_size = '0;
        matrix_a = '0; matrix_b = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk("rst_result", 256'(result_final), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_done", 256'(process_done), 256'(0));
        chk("rst_err", 256'(op_error), 256'(0));

        // reset in the middle of a 5x5 multiply
        op_code = 3'd2; matrix_size = 2'd3; matrix_a = {7{$urandom}}; matrix_b = {7{$urandom}};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        repeat (39) begin
            @(negedge clk);
            seen |= process_done;
        end
        chk("mid_no_done", 256'(seen), 256'(0));
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("mid_rst_busy", 256'(busy), 256'(0));
        chk("mid_rst_result", 256'(result_final), 256'(0));
        chk("mid_rst_done", 256'(process_done), 256'(0));
        repeat (3) @(negedge clk);
        chk("mid_rst_idle", 256'(busy), 256'(0));

        // add 2x2 with garbage outside the region
        a = {7{$urandom}}; b = {7{$urandom}};
        a[7:0] = 8'd1; a[15:8] = 8'd2; a[47:40] = 8'd3; a[55:48] = 8'd4;
        b[7:0] = 8'd10; b[15:8] = 8'd20; b[47:40] = 8'd30; b[55:48] = 8'd40;
        run_op(3'd0, 2'd0, a, b, 1'b0);
        chk("add_e0", 256'(result_final[7:0]), 256'(11));
        chk("add_e6", 256'(result_final[55:48]), 256'(44));
        chk("add_e2", 256'(result_final[23:16]), 256'(0));
        after_done(result_final);

        a = '0; b = '0;
        a[7:0] = 8'd100; b[7:0] = 8'd100;
        run_op(3'd0, 2'd3, a, b, 1'b0);
        chk("sat_add", 256'(result_final[7:0]), 256'(8'd127));
        a[7:0] = -8'sd100;
        run_op(3'd1, 2'd3, a, b, 1'b0);
        chk("sat_sub", 256'(result_final[7:0]), 256'(8'h80));
        a[7:0] = 8'h80;
        run_op(3'd5, 2'd3, a, b, 1'b0);
        chk("sat_neg", 256'(result_final[7:0]), 256'(8'd127));

        // multiply 3x3: identity times 1..9, then all-10 saturation
        a = '0; b = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                a[(r*5+c)*8 +: 8] = r == c ? 8'd1 : 8'd0;
                b[(r*5+c)*8 +: 8] = 8'(r*3 + c + 1);
            end
        run_op(3'd2, 2'd1, a, b, 1'b0);
        chk("mul_id", 256'(result_final), 256'(b));
        a = {25{8'd10}}; b = {25{8'd10}};
        run_op(3'd2, 2'd1, a, b, 1'b0);
        chk("mul_sat_e12", 256'(result_final[103:96]), 256'(8'd127));
        chk("mul_out_e3", 256'(result_final[31:24]), 256'(0));
        after_done(result_final);

        for (int i = 0; i < 25; i++) a[i*8 +: 8] = 8'(i);
        run_op(3'd4, 2'd3, a, b, 1'b0);
        chk("trn_e1", 256'(result_final[15:8]), 256'(5));

        a = {25{8'd3}}; b = {25{8'd77}}; b[7:0] = -8'sd2;
        run_op(3'd3, 2'd2, a, b, 1'b0);
        chk("scl_e18", 256'(result_final[151:144]), 256'(8'hFA));
        chk("scl_e4", 256'(result_final[39:32]), 256'(0));

        // start held high: back-to-back ops, invalid op last
        a = {7{$urandom}}; b = {7{$urandom}};
        run_op(3'd0, 2'd2, a, b, 1'b1);
        run_op(3'd7, 2'd3, a, b, 1'b1);
        r0 = result_final;
        start = 1'b0;
        after_done(r0);
        chk("inv_err_hold", 256'(op_error), 256'(1));
        @(negedge clk);
        chk("idle_busy", 256'(busy), 256'(0));

        for (int t = 0; t < 30; t++) begin
            a = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if (t % 3 == 0) begin
                for (int i = 0; i < 25; i++) a[i*8 +: 8] = 8'($urandom_range(0, 12)) - 8'd6;
            end
            run_op(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), a, b, 1'b0);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
